uart_rx_deserializer: RTL and testbench
=======================================

Name: uart_rx_deserializer

Overview:
- Serial-to-parallel UART receive stage, sitting directly upstream of the 4-entry receive buffer.
- Samples the asynchronous RxD line and recovers 8N1 frames (start bit, BITWIDTH data bits LSB first, one stop bit).
- For each good frame, drives a single-cycle write strobe with the received byte and a rotating 2-bit buffer address.
- Flags framing errors and line breaks; these never write the buffer.

Parameters:
- BITWIDTH, 8, data bits per frame and width of dataOut.
- CLKS_PER_BIT, 16, Clk cycles per bit period; even, >= 4.
- SYNC_STAGES, 2, flip-flops in the RxD synchronizer; >= 2.

Ports:
- Clk  input  1  system clock; all logic on rising edge.
- Rst  input  1  synchronous reset, active-high.
- RxD  input  1  asynchronous serial line; idles high.
- dataOut  output  BITWIDTH  received byte; valid while WR=1, held until next good frame.
- WR  output  1  one-cycle write strobe to the buffer.
- wpaddr  output  2  buffer address for the current WR; increments after each WR.
- FERR  output  1  one-cycle pulse: stop bit sampled low.
- BUSY  output  1  high in any state other than IDLE.

Behaviour:
- Reset: Rst=1 at a Clk edge forces the following on the next cycle:
  - state=IDLE; dataOut=0, WR=0, wpaddr=0, FERR=0, BUSY=0.
  - Synchronizer flops set to 1; bit counter and cycle counter cleared.
  - Reset mid-frame abandons the frame silently; no WR, no FERR.
- Synchronizer: rxs = RxD delayed SYNC_STAGES cycles. All decisions use rxs only.
- Cycle counter: 0..CLKS_PER_BIT-1. Bit counter: 0..BITWIDTH-1.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE:
  - rxs=0 -> START, cycle counter cleared.
  - Call the first cycle with rxs=0 cycle d.
- START:
  - Sample rxs at cycle d+CLKS_PER_BIT/2 (mid start bit).
  - rxs=0 -> DATA, counters cleared.
  - rxs=1 -> IDLE (glitch rejected: no WR, no FERR).
- DATA:
  - Data bit i is sampled at d+CLKS_PER_BIT/2+(i+1)*CLKS_PER_BIT.
  - Samples shift into the shift register LSB first.
  - After bit BITWIDTH-1 -> STOP.
- STOP: stop bit sampled at d+CLKS_PER_BIT/2+(BITWIDTH+1)*CLKS_PER_BIT.
  - rxs=1 (good frame):
    - Next cycle: dataOut=shift register, WR=1, wpaddr unchanged during the strobe.
    - The cycle after that: WR=0 and wpaddr=wpaddr+1 (mod 4; 3 wraps to 0).
    - State -> IDLE on the sample cycle. A new start bit can be detected on the cycle immediately after the stop sample, so back-to-back frames are supported.
  - rxs=0 (bad frame):
    - Next cycle: FERR=1 for one cycle; WR stays 0; dataOut and wpaddr unchanged.
    - -> BREAK.
- BREAK: stay until rxs=1, then -> IDLE. Covers break conditions (line held low).
- Latency, good frame: WR is high exactly at cycle t0+SYNC_STAGES+CLKS_PER_BIT/2+(BITWIDTH+1)*CLKS_PER_BIT+1, where t0 is the first edge that samples RxD=0. With defaults this is t0+155.
- Flow control: none. The buffer cannot back-pressure, and WR never stalls.
- Simultaneous events: WR and FERR are never high in the same cycle. Rst has priority over everything.
- BUSY: combinational from state (state != IDLE).

Test Plan:
- Defaults, send 0xA5 as 8N1 (16 clocks/bit) after reset -> WR high for exactly 1 cycle at t0+155, dataOut=0xA5, wpaddr=0; afterwards wpaddr=1, FERR never high.
- Four back-to-back frames 0x01, 0x80, 0xFF, 0x00 with no idle gap -> four WR pulses spaced 160 cycles apart, wpaddr 0,1,2,3, then wraps to 0; dataOut matches each byte.
- RxD low for 4 cycles only, then high -> BUSY rises, then FSM returns to IDLE after the start sample; no WR, no FERR.
- Frame 0x3C with stop bit driven low, line released 40 cycles later -> FERR pulses 1 cycle at t0+155, WR stays 0, dataOut keeps the prior value, BUSY stays high until rxs=1; a following good frame 0x5A then writes at wpaddr unchanged from before the error.
- Rst asserted at bit 4 of a frame -> next cycle all outputs 0, wpaddr=0; the remainder of the frame produces no WR; the next full frame 0x99 is received correctly at wpaddr=0.
- CLKS_PER_BIT=4, frame 0xC3 -> WR at t0+2+2+36+1=t0+41, dataOut=0xC3.

Source files
------------

// File: rtl/uart_rx_deserializer.sv
// UART 8N1 receive deserializer: recovers frames from RxD and writes
// good bytes into a 4-entry buffer via a one-cycle strobe.
//
// Ports:
//   Clk     in   system clock, rising edge
//   Rst     in   synchronous reset, active-high
//   RxD     in   asynchronous serial line, idles high
//   dataOut out  last good byte, valid while WR=1 and held afterwards
//   WR      out  one-cycle buffer write strobe
//   wpaddr  out  buffer address for the current WR, advances after it
//   FERR    out  one-cycle pulse when the stop bit is sampled low
//   BUSY    out  high whenever the receiver is not idle
module uart_rx_deserializer #(
    parameter int BITWIDTH     = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                RxD,
    output logic [BITWIDTH-1:0] dataOut,
    output logic                WR,
    output logic [1:0]          wpaddr,
    output logic                FERR,
    output logic                BUSY
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int BCW  = (BITWIDTH > 1) ? $clog2(BITWIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_e;

    state_e                state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [BCW-1:0]        bit_q, bit_d;
    logic [BITWIDTH-1:0]   shift_q, shift_d;
    logic [BITWIDTH-1:0]   data_q, data_d;
    logic                  wr_q, wr_d;
    logic                  ferr_q, ferr_d;
    logic [1:0]            addr_q, addr_d;

    logic rxs;
    logic half_tick;
    logic full_tick;
    logic last_bit;

    assign rxs       = sync_q[SYNC_STAGES-1];
    assign half_tick = (cnt_q == CW'(HALF - 1));
    assign full_tick = (cnt_q == CW'(CLKS_PER_BIT - 1));
    assign last_bit  = (bit_q == BCW'(BITWIDTH - 1));

    // State and datapath registers. Synchronizer resets to the idle
    // line level so a reset never fakes a start bit.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= S_IDLE;
            sync_q  <= '1;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
            ferr_q  <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[SYNC_STAGES-2:0], RxD};
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            ferr_q  <= ferr_d;
            addr_q  <= addr_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (!rxs) state_d = S_START;
            end
            S_START: begin
                if (half_tick) state_d = rxs ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (full_tick && last_bit) state_d = S_STOP;
            end
            S_STOP: begin
                if (full_tick) state_d = rxs ? S_IDLE : S_BREAK;
            end
            S_BREAK: begin
                if (rxs) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Counters, shift register and output strobes
    always_comb begin
        cnt_d   = full_tick ? '0 : cnt_q + CW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        wr_d    = 1'b0;
        ferr_d  = 1'b0;
        // Address advances on the cycle after each strobe.
        addr_d  = wr_q ? addr_q + 2'd1 : addr_q;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
            end
            S_START: begin
                // Realign the counter to mid start bit so every later
                // sample lands mid-bit on a full-period wrap.
                if (half_tick) cnt_d = '0;
                bit_d = '0;
            end
            S_DATA: begin
                if (full_tick) begin
                    shift_d = {rxs, shift_q[BITWIDTH-1:1]};
                    bit_d   = last_bit ? '0 : bit_q + BCW'(1);
                end
            end
            S_STOP: begin
                if (full_tick) begin
                    if (rxs) begin
                        wr_d   = 1'b1;
                        data_d = shift_q;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            S_BREAK: begin
                cnt_d = '0;
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    assign dataOut = data_q;
    assign WR      = wr_q;
    assign wpaddr  = addr_q;
    assign FERR    = ferr_q;
    assign BUSY    = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench for uart_rx_deserializer: frame-level model of
// expected writes/errors plus directed checks of timing literals.
module tb_uart_rx_deserializer;

    localparam int B   = 8;
    localparam int CPB = 16;
    localparam int SS  = 2;
    // Write strobe lands in the period ending at edge t0+LAT.
    localparam int LAT = SS + CPB / 2 + (B + 1) * CPB + 1;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic       RxD = 1'b1;
    logic       RxD4 = 1'b1;
    logic [7:0] dataOut, d4;
    logic       WR, wr4;
    logic [1:0] wpaddr, a4;
    logic       FERR, f4;
    logic       BUSY, b4;

    uart_rx_deserializer #(
        .BITWIDTH(B), .CLKS_PER_BIT(CPB), .SYNC_STAGES(SS)
    ) dut (
        .Clk(Clk), .Rst(Rst), .RxD(RxD),
        .dataOut(dataOut), .WR(WR), .wpaddr(wpaddr),
        .FERR(FERR), .BUSY(BUSY)
    );

    uart_rx_deserializer #(
        .BITWIDTH(8), .CLKS_PER_BIT(4), .SYNC_STAGES(2)
    ) dut4 (
        .Clk(Clk), .Rst(Rst), .RxD(RxD4),
        .dataOut(d4), .WR(wr4), .wpaddr(a4),
        .FERR(f4), .BUSY(b4)
    );

    always #5 Clk = ~Clk;

    // cyc == N during the period that follows posedge N.
    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        logic [7:0] b;
        bit         good;
    } ev_t;

    ev_t        evq[$];
    int         rst_edge = -1;
    bit         chk_en = 1'b0;
    int         checks = 0;
    int         failures = 0;
    logic [7:0] m_data;
    logic [1:0] m_addr;
    int         wr_log[$];
    logic [7:0] wr_dlog[$];
    logic [1:0] wr_alog[$];
    int         ferr_log[$];
    int         wr4_log[$];
    logic [7:0] wr4_dlog[$];
    int         f4_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Cycle-by-cycle compare against the frame-level model.
    always @(negedge Clk) begin : cmp
        logic ewr;
        logic eferr;
        ewr   = 1'b0;
        eferr = 1'b0;
        if (cyc == rst_edge) begin
            evq.delete();
            m_data = 8'h00;
            m_addr = 2'd0;
            chk_en = 1'b1;
            chk("rst_busy", {31'b0, BUSY}, 0);
        end
        if (chk_en) begin
            if (evq.size() > 0 && evq[0].at == cyc) begin
                if (evq[0].good) begin
                    ewr    = 1'b1;
                    m_data = evq[0].b;
                end else begin
                    eferr = 1'b1;
                end
                void'(evq.pop_front());
            end
            chk("wr", {31'b0, WR}, {31'b0, ewr});
            chk("ferr", {31'b0, FERR}, {31'b0, eferr});
            chk("dataOut", {24'b0, dataOut}, {24'b0, m_data});
            chk("wpaddr", {30'b0, wpaddr}, {30'b0, m_addr});
            if (WR) begin
                wr_log.push_back(cyc);
                wr_dlog.push_back(dataOut);
                wr_alog.push_back(wpaddr);
            end
            if (FERR) ferr_log.push_back(cyc);
            if (ewr) m_addr = m_addr + 2'd1;
        end
        if (wr4 === 1'b1) begin
            wr4_log.push_back(cyc);
            wr4_dlog.push_back(d4);
        end
        if (f4 === 1'b1) f4_cnt++;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) tick();
        @(negedge Clk);
    endtask

    task automatic do_reset();
        Rst      = 1'b1;
        rst_edge = cyc + 1;
        tick();
        Rst = 1'b0;
        repeat (4) tick();
    endtask

    task automatic clear_logs();
        wr_log.delete();
        wr_dlog.delete();
        wr_alog.delete();
        ferr_log.delete();
    endtask

    // Drives one frame; stop bit level is stop_ok. The line is left
    // at the stop level on return.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok,
                              output int t0);
        ev_t e;
        t0     = cyc + 1;
        e.at   = t0 + LAT - 1;
        e.b    = b;
        e.good = stop_ok;
        evq.push_back(e);
        RxD = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < B; i++) begin
            RxD = b[i];
            repeat (CPB) tick();
        end
        RxD = stop_ok;
        repeat (CPB) tick();
    endtask

    int t0;
    int ta[4];
    int tg;
    int t4;
    logic [7:0] bytes4[4];

    initial begin
        bytes4[0] = 8'h01;
        bytes4[1] = 8'h80;
        bytes4[2] = 8'hFF;
        bytes4[3] = 8'h00;

        tick();
        do_reset();
        @(negedge Clk);
        chk("reset_data", {24'b0, dataOut}, 0);
        chk("reset_addr", {30'b0, wpaddr}, 0);
        chk("reset_busy", {31'b0, BUSY}, 0);
        tick();

        // Single good frame
        clear_logs();
        send_frame(8'hA5, 1'b1, t0);
        repeat (20) tick();
        @(negedge Clk);
        chk("a5_count", wr_log.size(), 1);
        for (int i = 0; i < wr_log.size(); i++) begin
            chk("a5_time", wr_log[i] - t0, 154);
            chk("a5_data", {24'b0, wr_dlog[i]}, 32'hA5);
            chk("a5_addr", {30'b0, wr_alog[i]}, 0);
        end
        chk("a5_addr_after", {30'b0, wpaddr}, 1);
        chk("a5_ferr", ferr_log.size(), 0);
        tick();

        // Back-to-back frames with address wrap
        do_reset();
        clear_logs();
        for (int k = 0; k < 4; k++) send_frame(bytes4[k], 1'b1, ta[k]);
        repeat (20) tick();
        @(negedge Clk);
        chk("b2b_count", wr_log.size(), 4);
        for (int i = 0; i < wr_log.size(); i++) begin
            chk("b2b_data", {24'b0, wr_dlog[i]}, {24'b0, bytes4[i]});
            chk("b2b_addr", {30'b0, wr_alog[i]}, i);
            chk("b2b_time", wr_log[i] - ta[0], 154 + 160 * i);
        end
        chk("b2b_wrap", {30'b0, wpaddr}, 0);
        chk("b2b_last", {24'b0, dataOut}, 32'h00);
        tick();

        // Start-bit glitch
        clear_logs();
        tg  = cyc + 1;
        RxD = 1'b0;
        repeat (4) tick();
        RxD = 1'b1;
        wait_cyc(tg + 5);
        chk("glitch_busy", {31'b0, BUSY}, 1);
        wait_cyc(tg + 12);
        chk("glitch_idle", {31'b0, BUSY}, 0);
        repeat (10) tick();
        @(negedge Clk);
        chk("glitch_wr", wr_log.size(), 0);
        chk("glitch_ferr", ferr_log.size(), 0);
        tick();

        // Framing error then break, then a good frame
        clear_logs();
        send_frame(8'h3C, 1'b0, t0);
        wait_cyc(t0 + 199);
        chk("brk_busy_low", {31'b0, BUSY}, 1);
        RxD = 1'b1;
        wait_cyc(t0 + 201);
        chk("brk_busy_hold", {31'b0, BUSY}, 1);
        wait_cyc(t0 + 202);
        chk("brk_busy_idle", {31'b0, BUSY}, 0);
        chk("ferr_count", ferr_log.size(), 1);
        for (int i = 0; i < ferr_log.size(); i++)
            chk("ferr_time", ferr_log[i] - t0, 154);
        chk("ferr_nowr", wr_log.size(), 0);
        chk("ferr_data", {24'b0, dataOut}, 32'h00);
        chk("ferr_addr", {30'b0, wpaddr}, 0);
        repeat (10) tick();
        send_frame(8'h5A, 1'b1, t0);
        repeat (20) tick();
        @(negedge Clk);
        chk("5a_count", wr_log.size(), 1);
        for (int i = 0; i < wr_log.size(); i++) begin
            chk("5a_data", {24'b0, wr_dlog[i]}, 32'h5A);
            chk("5a_addr", {30'b0, wr_alog[i]}, 0);
        end
        chk("5a_addr_after", {30'b0, wpaddr}, 1);
        tick();

        // Reset in the middle of bit 4
        clear_logs();
        t0 = cyc + 1;
        fork
            begin
                int tf;
                send_frame(8'hF0, 1'b1, tf);
            end
            begin
                while (cyc < t0 + 87) tick();
                Rst      = 1'b1;
                rst_edge = cyc + 1;
                tick();
                Rst = 1'b0;
            end
        join
        repeat (20) tick();
        @(negedge Clk);
        chk("mid_rst_wr", wr_log.size(), 0);
        chk("mid_rst_data", {24'b0, dataOut}, 0);
        chk("mid_rst_addr", {30'b0, wpaddr}, 0);
        tick();
        send_frame(8'h99, 1'b1, t0);
        repeat (20) tick();
        @(negedge Clk);
        chk("99_count", wr_log.size(), 1);
        for (int i = 0; i < wr_log.size(); i++) begin
            chk("99_data", {24'b0, wr_dlog[i]}, 32'h99);
            chk("99_addr", {30'b0, wr_alog[i]}, 0);
            chk("99_time", wr_log[i] - t0, 154);
        end
        tick();

        // Four clocks per bit
        t4   = cyc + 1;
        RxD4 = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 8; i++) begin
            RxD4 = bytes4[0][0] ? 1'b1 : 1'b1;
            RxD4 = (8'hC3 >> i) & 8'h01 ? 1'b1 : 1'b0;
            repeat (4) tick();
        end
        RxD4 = 1'b1;
        repeat (20) tick();
        @(negedge Clk);
        chk("c4_count", wr4_log.size(), 1);
        for (int i = 0; i < wr4_log.size(); i++) begin
            chk("c4_time", wr4_log[i] - t4, 40);
            chk("c4_data", {24'b0, wr4_dlog[i]}, 32'hC3);
        end
        chk("c4_ferr", f4_cnt, 0);
        chk("c4_addr", {30'b0, a4}, 1);
        chk("pending_events", evq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
